branch_resolve_buffer: RTL and testbench

BRANCH_RESOLVE_BUFFER -- requirements
Module: branch_resolve_buffer

---
 rtl/branch_resolve_buffer_pkg.sv | 35 +++
 rtl/brb_select.sv | 56 +++++
 rtl/branch_resolve_buffer.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_buffer_pkg.sv
// Shared sys_defs types for the branch resolve buffer: branch masks, addresses,
// the completion packet and the stored-entry record.
package sys_defs;

  localparam int unsigned BRANCH_SZ     = 4;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned BRB_AGE_MAX_W = 8;

  typedef logic [BRANCH_SZ-1:0] B_MASK;
  typedef logic [BRANCH_SZ-1:0] B_MASK_MASK;
  typedef logic [XLEN-1:0]      ADDR;

  typedef struct packed {
    B_MASK bmm;
    logic  bm_mispred;
    ADDR   target_PC;
    logic  taken;
  } BRANCH_REG_PACKET;

  // age is sized for the largest supported buffer; only the low bits are compared
  typedef struct packed {
    logic                     valid;
    logic [BRB_AGE_MAX_W-1:0] age;
    B_MASK                    bmm;
    B_MASK                    dep_mask;
    logic                     mispred;
    logic                     taken;
    ADDR                      target_PC;
  } BRB_ENTRY;

  function automatic logic mask_hit(input B_MASK a, input B_MASK b);
    return |(a & b);
  endfunction

endpackage

// File: rtl/brb_select.sv
// Combinational pop selector: independent oldest mispredict first, otherwise the
// oldest valid entry; modulo age compare, ties to the lowest slot.
module brb_select
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AGE_W = 3
) (
  input  BRB_ENTRY         entries [DEPTH],
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] mis_ok;
  logic [DEPTH-1:0] valid_v;
  logic [DEPTH-1:0] pool;
  logic [AGE_W-1:0] diff;
  logic             win;
  logic             unused_bits;

  always_comb begin
    mis_ok      = '0;
    valid_v     = '0;
    unused_bits = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_bits = unused_bits ^ (^entries[i]);
      valid_v[i]  = entries[i].valid;
      mis_ok[i]   = entries[i].valid && entries[i].mispred;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && entries[j].valid && entries[j].mispred &&
            mask_hit(entries[i].dep_mask, entries[j].bmm))
          mis_ok[i] = 1'b0;
      end
    end
  end

  assign pool = (|mis_ok) ? mis_ok : valid_v;

  // j is older than i when (age_j - age_i) is negative in AGE_W-bit arithmetic
  always_comb begin
    grant = '0;
    diff  = '0;
    win   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      win = pool[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && pool[j]) begin
          diff = entries[j].age[AGE_W-1:0] - entries[i].age[AGE_W-1:0];
          if (diff[AGE_W-1] || (diff == '0 && j < i))
            win = 1'b0;
        end
      end
      grant[i] = win;
    end
  end

endmodule

// File: rtl/branch_resolve_buffer.sv
// Branch resolve buffer: stores resolved branches and retires one per cycle.
// Define BRB_BYPASS_EN for same-cycle completion of lanes into an empty buffer.
`ifndef N
`define N 2
`endif

module branch_resolve_buffer
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned N_IN  = `N
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_IN-1:0]              in_valid,
  input  B_MASK_MASK [N_IN-1:0]        in_bmm,
  input  B_MASK [N_IN-1:0]             in_dep_mask,
  input  logic [N_IN-1:0]              in_mispred,
  input  logic [N_IN-1:0]              in_taken,
  input  ADDR [N_IN-1:0]               in_target_PC,
  output logic                         in_ready,
  output BRANCH_REG_PACKET             branch_completing,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int unsigned AGE_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  BRB_ENTRY         slots   [DEPTH];
  BRB_ENTRY         slots_n [DEPTH];
  BRB_ENTRY         lane_e;
  logic [AGE_W-1:0] age_ctr, age_n;
  logic [DEPTH-1:0] grant, used;
  logic [N_IN-1:0]  byp_lane;
  logic [CNT_W-1:0] cnt;
  BRANCH_REG_PACKET stored_pkt;
  B_MASK            pop_bmm;
  logic             pop_mis, pop_any, placed, dup;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt = cnt + CNT_W'(slots[i].valid);
  end
  assign out_count = cnt;

  assign in_ready = (32'(out_count) + N_IN) <= DEPTH;

  brb_select #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_select (
    .entries (slots),
    .grant   (grant)
  );

  always_comb begin
    stored_pkt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        stored_pkt.bmm        = slots[i].bmm;
        stored_pkt.bm_mispred = slots[i].mispred;
        stored_pkt.target_PC  = slots[i].target_PC;
        stored_pkt.taken      = slots[i].taken;
      end
    end
  end

`ifdef BRB_BYPASS_EN
  logic [N_IN-1:0] lane_mis, pick;

  always_comb begin
    lane_mis = '0;
    pick     = '0;
    byp_lane = '0;
    for (int unsigned l = 0; l < N_IN; l++) begin
      lane_mis[l] = in_valid[l] && in_mispred[l];
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (k != l && in_valid[k] && in_mispred[k] && mask_hit(in_dep_mask[l], in_bmm[k]))
          lane_mis[l] = 1'b0;
      end
    end
    if (reset_n && out_count == '0) begin
      pick = (|lane_mis) ? lane_mis : in_valid;
      for (int unsigned l = 0; l < N_IN; l++)
        if (pick[l] && byp_lane == '0) byp_lane[l] = 1'b1;
    end
  end
`else
  assign byp_lane = '0;
`endif

  always_comb begin
    branch_completing = stored_pkt;
    for (int unsigned l = 0; l < N_IN; l++) begin
      if (byp_lane[l]) begin
        branch_completing.bmm        = in_bmm[l];
        branch_completing.bm_mispred = in_mispred[l];
        branch_completing.target_PC  = in_target_PC[l];
        branch_completing.taken      = in_taken[l];
      end
    end
  end

  assign pop_bmm = branch_completing.bmm;
  assign pop_mis = branch_completing.bm_mispred;
  assign pop_any = |pop_bmm;

  // Incoming lanes see the same squash/clear as stored entries, then fill
  // slots that are free before this edge (freed slots are reused next cycle).
  always_comb begin
    slots_n = slots;
    age_n   = age_ctr;
    used    = '0;
    lane_e  = '0;
    placed  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      used[i] = slots[i].valid;
      if (grant[i]) begin
        slots_n[i].valid = 1'b0;
      end else if (slots[i].valid && pop_any) begin
        if (pop_mis) begin
          if (mask_hit(slots[i].dep_mask, pop_bmm)) slots_n[i].valid = 1'b0;
        end else begin
          slots_n[i].dep_mask = slots[i].dep_mask & ~pop_bmm;
        end
      end
    end
    if (in_ready) begin
      for (int unsigned l = 0; l < N_IN; l++) begin
        if (in_valid[l] && !byp_lane[l]) begin
          lane_e           = '0;
          lane_e.valid     = 1'b1;
          lane_e.age       = BRB_AGE_MAX_W'(age_n);
          lane_e.bmm       = in_bmm[l];
          lane_e.dep_mask  = in_dep_mask[l];
          lane_e.mispred   = in_mispred[l];
          lane_e.taken     = in_taken[l];
          lane_e.target_PC = in_target_PC[l];
          age_n            = age_n + 1'b1;
          if (pop_any) begin
            if (pop_mis) begin
              if (mask_hit(lane_e.dep_mask, pop_bmm)) lane_e.valid = 1'b0;
            end else begin
              lane_e.dep_mask = lane_e.dep_mask & ~pop_bmm;
            end
          end
          placed = !lane_e.valid;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!placed && !used[i]) begin
              slots_n[i] = lane_e;
              used[i]    = 1'b1;
              placed     = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
      age_ctr <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= slots_n[i];
      age_ctr <= age_n;
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int unsigned l = 0; l < N_IN; l++)
      for (int unsigned i = 0; i < DEPTH; i++)
        if (in_ready && in_valid[l] && slots[i].valid && slots[i].bmm == in_bmm[l])
          dup = 1'b1;
  end

  a_unique_bmm: assert property (@(posedge clock) disable iff (!reset_n) !dup);

endmodule

// File: tb/tb_branch_resolve_buffer.sv
// Directed bench for branch_resolve_buffer (DEPTH=4, N_IN=2): table-driven
// stream plus hand-written reset and bypass sequences.
module tb_branch_resolve_buffer;
  import sys_defs::*;

  typedef struct packed {
    logic  v;
    B_MASK bmm;
    B_MASK dep;
    logic  mis;
    logic  taken;
    ADDR   tgt;
  } lane_t;

  typedef struct packed {
    logic       ready;
    logic [2:0] count;
    B_MASK      bmm;
    logic       mis;
    ADDR        tgt;
    logic       taken;
  } exp_t;

  typedef struct packed {
    lane_t l0;
    lane_t l1;
    exp_t  e;
  } vec_t;

  localparam int    NV  = 26;
  localparam lane_t NOL = '0;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [1:0]        in_valid;
  B_MASK_MASK [1:0]  in_bmm;
  B_MASK [1:0]       in_dep_mask;
  logic [1:0]        in_mispred;
  logic [1:0]        in_taken;
  ADDR [1:0]         in_target_PC;
  logic              in_ready;
  BRANCH_REG_PACKET  branch_completing;
  logic [2:0]        out_count;

  vec_t vecs [NV];
  int   tests = 0;
  int   fails = 0;

  branch_resolve_buffer #(.DEPTH(4), .N_IN(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_bmm            (in_bmm),
    .in_dep_mask       (in_dep_mask),
    .in_mispred        (in_mispred),
    .in_taken          (in_taken),
    .in_target_PC      (in_target_PC),
    .in_ready          (in_ready),
    .branch_completing (branch_completing),
    .out_count         (out_count)
  );

  always #5 clock = ~clock;

  function automatic lane_t ln(input logic [3:0] bmm, input logic [3:0] dep,
                               input logic mis, input logic taken, input logic [31:0] tgt);
    lane_t r;
    r.v = 1'b1; r.bmm = bmm; r.dep = dep; r.mis = mis; r.taken = taken; r.tgt = tgt;
    return r;
  endfunction

  function automatic exp_t ex(input logic ready, input logic [2:0] count, input logic [3:0] bmm,
                              input logic mis, input logic [31:0] tgt, input logic taken);
    exp_t r;
    r.ready = ready; r.count = count; r.bmm = bmm; r.mis = mis; r.tgt = tgt; r.taken = taken;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input lane_t a, input lane_t b);
    in_valid        = {b.v, a.v};
    in_bmm[0]       = a.bmm;   in_bmm[1]       = b.bmm;
    in_dep_mask[0]  = a.dep;   in_dep_mask[1]  = b.dep;
    in_mispred      = {b.mis, a.mis};
    in_taken        = {b.taken, a.taken};
    in_target_PC[0] = a.tgt;   in_target_PC[1] = b.tgt;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    BRANCH_REG_PACKET p;
    p.bmm = e.bmm; p.bm_mispred = e.mis; p.target_PC = e.tgt; p.taken = e.taken;
    chk({tag, "_ready"}, 64'(in_ready), 64'(e.ready));
    chk({tag, "_count"}, 64'(out_count), 64'(e.count));
    chk({tag, "_pkt"}, 64'(branch_completing), 64'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ordering, mispredict priority/squash, mask clear, full, modulo age wrap
    vecs[0]  = '{ln(4'h1, 4'h0, 1'b0, 1'b1, 32'h10),  NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[1]  = '{ln(4'h2, 4'h0, 1'b0, 1'b0, 32'h20),  NOL, ex(1'b1, 3'd1, 4'h1, 1'b0, 32'h10, 1'b1)};
    vecs[2]  = '{NOL, NOL, ex(1'b1, 3'd1, 4'h2, 1'b0, 32'h20, 1'b0)};
    vecs[3]  = '{NOL, NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[4]  = '{ln(4'h2, 4'h1, 1'b1, 1'b1, 32'h200), ln(4'h1, 4'h0, 1'b1, 1'b0, 32'h100),
                 ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[5]  = '{NOL, NOL, ex(1'b1, 3'd2, 4'h1, 1'b1, 32'h100, 1'b0)};
    vecs[6]  = '{NOL, NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[7]  = '{ln(4'h1, 4'h0, 1'b0, 1'b0, 32'h11),  ln(4'h2, 4'h1, 1'b0, 1'b1, 32'h22),
                 ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[8]  = '{ln(4'h4, 4'h3, 1'b0, 1'b1, 32'h44),  NOL, ex(1'b1, 3'd2, 4'h1, 1'b0, 32'h11, 1'b0)};
    vecs[9]  = '{ln(4'h1, 4'h0, 1'b1, 1'b1, 32'h300), NOL, ex(1'b1, 3'd2, 4'h2, 1'b0, 32'h22, 1'b1)};
    vecs[10] = '{ln(4'h2, 4'h0, 1'b1, 1'b0, 32'h500), NOL, ex(1'b1, 3'd2, 4'h1, 1'b1, 32'h300, 1'b1)};
    vecs[11] = '{NOL, NOL, ex(1'b1, 3'd2, 4'h2, 1'b1, 32'h500, 1'b0)};
    vecs[12] = '{NOL, NOL, ex(1'b1, 3'd1, 4'h4, 1'b0, 32'h44, 1'b1)};
    vecs[13] = '{NOL, NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[14] = '{ln(4'h1, 4'h0, 1'b0, 1'b0, 32'h1000), ln(4'h2, 4'h0, 1'b0, 1'b0, 32'h2000),
                 ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[15] = '{ln(4'h4, 4'h0, 1'b0, 1'b1, 32'h4000), ln(4'h8, 4'h0, 1'b0, 1'b1, 32'h8000),
                 ex(1'b1, 3'd2, 4'h1, 1'b0, 32'h1000, 1'b0)};
    vecs[16] = '{ln(4'h1, 4'h0, 1'b0, 1'b0, 32'h9999), NOL, ex(1'b0, 3'd3, 4'h2, 1'b0, 32'h2000, 1'b0)};
    vecs[17] = '{NOL, NOL, ex(1'b1, 3'd2, 4'h4, 1'b0, 32'h4000, 1'b1)};
    vecs[18] = '{NOL, NOL, ex(1'b1, 3'd1, 4'h8, 1'b0, 32'h8000, 1'b1)};
    vecs[19] = '{NOL, NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[20] = '{ln(4'h1, 4'h0, 1'b0, 1'b0, 32'hA1), ln(4'h2, 4'h0, 1'b0, 1'b0, 32'hA2),
                 ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};
    vecs[21] = '{ln(4'h4, 4'h0, 1'b0, 1'b1, 32'hA4), NOL, ex(1'b1, 3'd2, 4'h1, 1'b0, 32'hA1, 1'b0)};
    vecs[22] = '{ln(4'h8, 4'h0, 1'b0, 1'b1, 32'hA8), NOL, ex(1'b1, 3'd2, 4'h2, 1'b0, 32'hA2, 1'b0)};
    vecs[23] = '{NOL, NOL, ex(1'b1, 3'd2, 4'h4, 1'b0, 32'hA4, 1'b1)};
    vecs[24] = '{NOL, NOL, ex(1'b1, 3'd1, 4'h8, 1'b0, 32'hA8, 1'b1)};
    vecs[25] = '{NOL, NOL, ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0)};

    reset_n = 1'b0;
    drive(NOL, NOL);
    #1;
    check_out("reset", ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

`ifndef BRB_BYPASS_EN
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].l0, vecs[i].l1);
      #1;
      check_out($sformatf("row%0d", i), vecs[i].e);
      @(posedge clock); #1;
    end

    // three stored entries, then asynchronous reset between edges
    drive(ln(4'h1, 4'h0, 1'b0, 1'b0, 32'hB1), ln(4'h2, 4'h0, 1'b0, 1'b0, 32'hB2));
    @(posedge clock); #1;
    drive(ln(4'h4, 4'h0, 1'b0, 1'b0, 32'hB4), ln(4'h8, 4'h0, 1'b0, 1'b0, 32'hB8));
    @(posedge clock); #1;
    drive(ln(4'h1, 4'h0, 1'b0, 1'b0, 32'hC1), NOL);
    #1;
    chk("pre_reset_count", 64'(out_count), 64'd3);
    chk("pre_reset_ready", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check_out("mid_reset", ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0));
    @(posedge clock); #1;
    chk("reset_hold_count", 64'(out_count), 64'd0);
    #3;
    reset_n = 1'b1;
    #1;
    chk("post_deassert_count", 64'(out_count), 64'd0);
    @(posedge clock); #1;
    drive(NOL, NOL);
    #1;
    check_out("first_accept", ex(1'b1, 3'd1, 4'h1, 1'b0, 32'hC1, 1'b0));
    @(posedge clock); #1;
    chk("drain_count", 64'(out_count), 64'd0);
`else
    drive(ln(4'h8, 4'h0, 1'b1, 1'b0, 32'h100), NOL);
    #1;
    check_out("bypass", ex(1'b1, 3'd0, 4'h8, 1'b1, 32'h100, 1'b0));
    @(posedge clock); #1;
    drive(NOL, NOL);
    #1;
    check_out("bypass_after", ex(1'b1, 3'd0, 4'h0, 1'b0, 32'h0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
